ps2_frame_receiver: RTL

//   Receives PS/2 device-to-host frames: 1 start, 8 data bits (LSB first), 1 odd parity, 1 stop.

---
 rtl/ps2_frame_receiver_pkg.sv | 19 +
 rtl/ps2_frame_receiver_if.sv | 30 +++
 rtl/ps2_frame_receiver_falling_edge_detector.sv | 19 +
 rtl/ps2_frame_receiver.sv | 99 +++++++++
 4 files changed

// File: rtl/ps2_frame_receiver_pkg.sv
// Shared definitions for the PS/2 device-to-host frame receiver.
package ps2_frame_receiver_pkg;

   localparam int unsigned PS2_DATA_BITS   = 8;
   localparam int unsigned BIT_COUNT_WIDTH = $clog2(PS2_DATA_BITS);

   typedef enum logic [1:0] {
      STATE_IDLE,
      STATE_DATA,
      STATE_PARITY,
      STATE_STOP
   } rxState_t;

   // True when data plus the parity bit hold an odd number of ones.
   function automatic logic oddParityOk(input logic [PS2_DATA_BITS-1:0] data, input logic parity);
      return (^data) ^ parity;
   endfunction

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// Byte delivery and error-pulse bundle between the receiver and the keyboard controller.
interface ps2_frame_receiver_if;
   import ps2_frame_receiver_pkg::*;

   logic [PS2_DATA_BITS-1:0] dataOut;
   logic                     dataValid;
   logic                     dataAck;
   logic                     parityError;
   logic                     frameError;
   logic                     overrun;

   modport master (
      output dataOut,
      output dataValid,
      input  dataAck,
      output parityError,
      output frameError,
      output overrun
   );

   modport slave (
      input  dataOut,
      input  dataValid,
      output dataAck,
      input  parityError,
      input  frameError,
      input  overrun
   );

endinterface

// File: rtl/ps2_frame_receiver_falling_edge_detector.sv
// Registered-history falling edge detector for an already synchronized level.
module ps2_frame_receiver_falling_edge_detector (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic fall_c
);

   logic prevLevel;

   // Track the previous level; resets high so an idle-high line gives no edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) prevLevel <= 1'b1;
      else       prevLevel <= level;
   end

   assign fall_c = prevLevel & ~level;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
module ps2_frame_receiver
   import ps2_frame_receiver_pkg::*;
#(
   parameter int unsigned timeoutWidth = 16,
   parameter int unsigned timeoutValue = 50000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ps2Clock,
   input  logic                  ps2Data,
   ps2_frame_receiver_if.master  rxBus
);

   localparam logic [timeoutWidth-1:0] TIMEOUT_LAST = timeoutWidth'(timeoutValue - 1);
   localparam logic [BIT_COUNT_WIDTH-1:0] LAST_BIT  = BIT_COUNT_WIDTH'(PS2_DATA_BITS - 1);

   rxState_t                   state;
   logic [timeoutWidth-1:0]    counter;
   logic [BIT_COUNT_WIDTH-1:0] bitCount;
   logic [PS2_DATA_BITS-1:0]   shift;
   logic                       parityOk;
   logic                       fall;

   ps2_frame_receiver_falling_edge_detector u_clockEdge (
      .clock  (clock),
      .reset  (reset),
      .level  (ps2Clock),
      .fall_c (fall)
   );

   // Frame FSM, inter-edge watchdog and one-deep holding register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= STATE_IDLE;
         counter           <= '0;
         bitCount          <= '0;
         shift             <= '0;
         parityOk          <= 1'b0;
         rxBus.dataOut     <= '0;
         rxBus.dataValid   <= 1'b0;
         rxBus.parityError <= 1'b0;
         rxBus.frameError  <= 1'b0;
         rxBus.overrun     <= 1'b0;
      end else begin
         rxBus.parityError <= 1'b0;
         rxBus.frameError  <= 1'b0;
         rxBus.overrun     <= 1'b0;

         // Consumer ack empties the holding register unless a new byte lands this edge.
         if (rxBus.dataValid && rxBus.dataAck) rxBus.dataValid <= 1'b0;

         if (fall) begin
            counter <= '0;
            case (state)
               STATE_IDLE: begin
                  if (!ps2Data) begin
                     state    <= STATE_DATA;
                     bitCount <= '0;
                  end
               end
               STATE_DATA: begin
                  shift    <= {ps2Data, shift[PS2_DATA_BITS-1:1]};
                  bitCount <= bitCount + BIT_COUNT_WIDTH'(1);
                  if (bitCount == LAST_BIT) state <= STATE_PARITY;
               end
               STATE_PARITY: begin
                  parityOk <= oddParityOk(shift, ps2Data);
                  state    <= STATE_STOP;
               end
               STATE_STOP: begin
                  state <= STATE_IDLE;
                  if (!ps2Data) begin
                     rxBus.frameError <= 1'b1;
                  end else if (!parityOk) begin
                     rxBus.parityError <= 1'b1;
                  end else if (rxBus.dataValid && !rxBus.dataAck) begin
                     rxBus.overrun <= 1'b1;
                  end else begin
                     rxBus.dataOut   <= shift;
                     rxBus.dataValid <= 1'b1;
                  end
               end
               default: state <= STATE_IDLE;
            endcase
         end else if (state == STATE_IDLE) begin
            counter <= '0;
         end else if (counter == TIMEOUT_LAST) begin
            // Device stopped clocking mid-frame: abandon the partial frame.
            state            <= STATE_IDLE;
            counter          <= '0;
            rxBus.frameError <= 1'b1;
         end else begin
            counter <= counter + timeoutWidth'(1);
         end
      end
   end

endmodule
